// File: rtl/quadrature_encoder_pkg.sv
// Shared types and constants for the quadrature encoder generator.
//   qenc_state_e : FSM state (StStop, StRun)
//   Phase0..3    : Gray-coded {A, B} phases in CCW order 00, 01, 11, 10
//   MinPeriod    : smallest legal nonzero step period, in clocks
//   next_phase() : one-step phase advance in either direction
package quadrature_encoder_pkg;

   typedef enum logic {
      StStop,
      StRun
   } qenc_state_e;

   localparam logic [1:0] Phase0 = 2'b00;
   localparam logic [1:0] Phase1 = 2'b01;
   localparam logic [1:0] Phase2 = 2'b11;
   localparam logic [1:0] Phase3 = 2'b10;

   localparam int unsigned MinPeriod = 2;

   // ccw = 1 walks 00->01->11->10, ccw = 0 walks the reverse; always a single Gray step
   function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic ccw);
      logic [1:0] n;
      case (ph)
         Phase0:  n = ccw ? Phase1 : Phase3;
         Phase1:  n = ccw ? Phase2 : Phase0;
         Phase2:  n = ccw ? Phase3 : Phase1;
         default: n = ccw ? Phase0 : Phase2;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/quadrature_phase_stepper.sv
// 2-bit Gray phase register for the emulated encoder channels.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_step         : advance the phase by one step this cycle
//   i_ccw          : step direction (1 = CCW, 0 = CW)
//   o_phase        : registered {A, B}
//   o_a_rise       : the step taken this cycle raises A
module quadrature_phase_stepper
   import quadrature_encoder_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_step,
   input  logic       i_ccw,
   output logic [1:0] o_phase,
   output logic       o_a_rise
);

   logic [1:0] r_phase;
   logic [1:0] w_phase_next;

   assign w_phase_next = next_phase(r_phase, i_ccw);
   assign o_a_rise     = i_step & w_phase_next[1] & ~r_phase[1];
   assign o_phase      = r_phase;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= Phase0;
      end else if (i_step) begin
         r_phase <= w_phase_next;
      end
   end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// Avalon-MM controlled quadrature encoder emulator.
// Ports:
//   clk_clk, rst_reset_n   : clock, asynchronous active-low reset
//   avalon_slave_*         : addr 0 = signed speed (clocks/step, sign = direction),
//                            addr 1 = position counter; zero-wait-state reads
//   encoded_out            : registered {A, B}
//   index_out              : once-per-revolution pulse (only with QENC_INDEX_EN)
// Build option: define QENC_INDEX_EN to add the modulo-CPR step counter and index_out.
module quadrature_encoder_gen
   import quadrature_encoder_pkg::*;
#(
   parameter int unsigned PERIOD_W = 24,
   parameter int unsigned POS_W    = 32,
   parameter int unsigned CPR      = 28
) (
   input  logic        clk_clk,
   input  logic        rst_reset_n,
   input  logic        avalon_slave_address,
   input  logic [31:0] avalon_slave_writedata,
   output logic [31:0] avalon_slave_readdata,
   input  logic        avalon_slave_write,
   input  logic        avalon_slave_read,
   output logic [1:0]  encoded_out
`ifdef QENC_INDEX_EN
   ,
   output logic        index_out
`endif
);

   localparam logic [32:0] MaxMag = (33'd1 << PERIOD_W) - 33'd1;

   // |speed| saturated to the timer width; nonzero values below MinPeriod are raised to it
   function automatic logic [PERIOD_W-1:0] speed_mag(input logic [31:0] s);
      logic [31:0] a;
      a = s[31] ? (~s + 32'd1) : s;
      if ({1'b0, a} > MaxMag) return '1;
      else if (a == 32'd0) return '0;
      else if (a < 32'(MinPeriod)) return PERIOD_W'(MinPeriod);
      else return a[PERIOD_W-1:0];
   endfunction

   qenc_state_e         r_state;
   logic [PERIOD_W-1:0] r_timer;
   logic [31:0]         r_speed;
   logic [POS_W-1:0]    r_pos;

   logic                w_speed_wr;
   logic                w_pos_wr;
   logic                w_boundary;
   logic                w_step;
   logic                w_ccw;
   logic                w_a_rise;
   logic [PERIOD_W-1:0] w_wr_mag;
   logic [PERIOD_W-1:0] w_cur_mag;
   logic                w_unused_read;

   assign w_speed_wr    = avalon_slave_write & ~avalon_slave_address;
   assign w_pos_wr      = avalon_slave_write & avalon_slave_address;
   assign w_wr_mag      = speed_mag(avalon_slave_writedata);
   assign w_cur_mag     = speed_mag(r_speed);
   assign w_unused_read = avalon_slave_read;

   // Step direction and period come from the speed stored at the boundary, so a write
   // mid-step only takes effect when the running timer expires.
   assign w_boundary = (r_state == StRun) && (r_timer <= PERIOD_W'(1));
   assign w_step     = w_boundary && (r_speed != 32'd0);
   assign w_ccw      = ~r_speed[31];

   always_ff @(posedge clk_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         r_state <= StStop;
         r_timer <= '0;
         r_speed <= '0;
      end else begin
         if (w_speed_wr) begin
            r_speed <= avalon_slave_writedata;
         end
         case (r_state)
            StStop: begin
               if (w_speed_wr && (w_wr_mag != '0)) begin
                  r_timer <= w_wr_mag;
                  r_state <= StRun;
               end
            end
            StRun: begin
               if (!w_boundary) begin
                  r_timer <= r_timer - PERIOD_W'(1);
               end else if (r_speed == 32'd0) begin
                  r_timer <= '0;
                  r_state <= StStop;
               end else begin
                  r_timer <= w_cur_mag;
               end
            end
         endcase
      end
   end

   quadrature_phase_stepper u_stepper (
      .i_clk    (clk_clk),
      .i_rst_n  (rst_reset_n),
      .i_step   (w_step),
      .i_ccw    (w_ccw),
      .o_phase  (encoded_out),
      .o_a_rise (w_a_rise)
   );

   // Bus write takes priority over a coincident A rise
   always_ff @(posedge clk_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         r_pos <= '0;
      end else if (w_pos_wr) begin
         r_pos <= avalon_slave_writedata[POS_W-1:0];
      end else if (w_a_rise) begin
         r_pos <= w_ccw ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
      end
   end

   always_comb begin
      avalon_slave_readdata = r_speed;
      if (avalon_slave_address) begin
         avalon_slave_readdata = 32'(signed'(r_pos));
      end
   end

`ifdef QENC_INDEX_EN
   localparam int unsigned IdxW = (CPR > 1) ? $clog2(CPR) : 1;

   logic [IdxW-1:0] r_step_cnt;
   logic [IdxW-1:0] w_step_cnt_next;
   logic            r_index;

   always_comb begin
      w_step_cnt_next = r_step_cnt;
      if (w_ccw) begin
         w_step_cnt_next = (r_step_cnt == IdxW'(CPR - 1)) ? '0 : r_step_cnt + IdxW'(1);
      end else begin
         w_step_cnt_next = (r_step_cnt == '0) ? IdxW'(CPR - 1) : r_step_cnt - IdxW'(1);
      end
   end

   // Index is registered alongside the phase so it spans exactly the zero-count step
   always_ff @(posedge clk_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         r_step_cnt <= '0;
         r_index    <= 1'b0;
      end else if (w_step) begin
         r_step_cnt <= w_step_cnt_next;
         r_index    <= (w_step_cnt_next == '0);
      end
   end

   assign index_out = r_index;
`endif

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Directed self-checking bench for quadrature_encoder_gen.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Define QENC_INDEX_EN to include the index pulse checks.
module tb_quadrature_encoder_gen;

   logic        clk_clk = 1'b0;
   logic        rst_reset_n = 1'b0;
   logic        avalon_slave_address = 1'b0;
   logic [31:0] avalon_slave_writedata = '0;
   logic [31:0] avalon_slave_readdata;
   logic        avalon_slave_write = 1'b0;
   logic        avalon_slave_read = 1'b0;
   logic [1:0]  encoded_out;
`ifdef QENC_INDEX_EN
   logic        index_out;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #10 clk_clk = ~clk_clk;

   quadrature_encoder_gen dut (
      .clk_clk                (clk_clk),
      .rst_reset_n            (rst_reset_n),
      .avalon_slave_address   (avalon_slave_address),
      .avalon_slave_writedata (avalon_slave_writedata),
      .avalon_slave_readdata  (avalon_slave_readdata),
      .avalon_slave_write     (avalon_slave_write),
      .avalon_slave_read      (avalon_slave_read),
      .encoded_out            (encoded_out)
`ifdef QENC_INDEX_EN
      ,
      .index_out              (index_out)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   // Called at a falling edge; the write is taken at the next rising edge and the
   // task returns on the falling edge after it.
   task automatic bus_write(input logic addr, input logic [31:0] data);
      avalon_slave_address   = addr;
      avalon_slave_writedata = data;
      avalon_slave_write     = 1'b1;
      @(negedge clk_clk);
      avalon_slave_write     = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic addr, input logic [31:0] exp);
      avalon_slave_address = addr;
      avalon_slave_read    = 1'b1;
      #1;
      check_eq(tag, avalon_slave_readdata, exp);
      avalon_slave_read    = 1'b0;
   endtask

   task automatic enc_check(input string tag, input logic [1:0] exp);
      check_eq(tag, {30'd0, encoded_out}, {30'd0, exp});
   endtask

   initial begin
      // Reset state
      cycles(3);
      enc_check("reset_enc", 2'b00);
      read_check("reset_speed", 1'b0, 32'd0);
      read_check("reset_pos", 1'b1, 32'd0);
      rst_reset_n = 1'b1;
      cycles(2);

      // Speed 100 from STOP: first edge exactly 100 cycles after the write
      bus_write(1'b0, 32'd100);
      cycles(99);  enc_check("s100_before_first", 2'b00);
      cycles(1);   enc_check("s100_first_edge", 2'b01);
      read_check("s100_pos0", 1'b1, 32'd0);
      cycles(100); enc_check("s100_step2", 2'b11);
      read_check("s100_pos1", 1'b1, 32'd1);
      cycles(99);  enc_check("s100_hold", 2'b11);
      cycles(1);   enc_check("s100_step3", 2'b10);
      cycles(200); enc_check("s100_step5", 2'b01);
      cycles(100); enc_check("s100_step6", 2'b11);
      read_check("s100_pos2", 1'b1, 32'd2);

      // Reverse mid-step: running timer finishes, then one step backward
      cycles(50);
      bus_write(1'b0, -32'sd100);
      read_check("rev_speed", 1'b0, 32'hFFFF_FF9C);
      cycles(48);  enc_check("rev_before_boundary", 2'b11);
      cycles(1);   enc_check("rev_back_one", 2'b01);
      cycles(100); enc_check("rev_back_two", 2'b00);
      cycles(100); enc_check("rev_back_three", 2'b10);
      read_check("rev_pos", 1'b1, 32'd1);

      // Speed 1 clamps to a 2-cycle period, applied at the next boundary
      bus_write(1'b0, 32'd1);
      cycles(98);  enc_check("clamp_before", 2'b10);
      cycles(1);   enc_check("clamp_first", 2'b00);
      cycles(1);   enc_check("clamp_hold", 2'b00);
      cycles(1);   enc_check("clamp_second", 2'b01);
      cycles(2);   enc_check("clamp_third", 2'b11);
      read_check("clamp_pos", 1'b1, 32'd2);

      // Position wrap past 0x7FFFFFFF on the next A rise
      bus_write(1'b1, 32'h7FFF_FFFF);
      read_check("wrap_loaded", 1'b1, 32'h7FFF_FFFF);
      cycles(6);   read_check("wrap_no_rise", 1'b1, 32'h7FFF_FFFF);
      cycles(1);   enc_check("wrap_enc", 2'b11);
      read_check("wrap_pos", 1'b1, 32'h8000_0000);

      // Position write coinciding with an A rise: write wins
      cycles(7);
      bus_write(1'b1, 32'h0001_2345);
      enc_check("coll_enc", 2'b11);
      read_check("coll_pos", 1'b1, 32'h0001_2345);

      // Speed 0: stops at the next boundary, AB held
      bus_write(1'b0, 32'd0);
      cycles(20);  enc_check("stop_hold", 2'b11);
      read_check("stop_speed", 1'b0, 32'd0);
      read_check("stop_pos", 1'b1, 32'h0001_2345);

      // Reset asserted mid-step aborts; no edge afterwards without a new write
      bus_write(1'b0, 32'd30);
      cycles(45);
      #3 rst_reset_n = 1'b0;
      #1 enc_check("rst_mid_enc", 2'b00);
      read_check("rst_mid_pos", 1'b1, 32'd0);
      @(negedge clk_clk);
      rst_reset_n = 1'b1;
      cycles(100); enc_check("rst_quiet", 2'b00);
      read_check("rst_speed", 1'b0, 32'd0);

      // Speed -50: CW sequence, position -10 after 2000 cycles
      bus_write(1'b0, -32'sd50);
      cycles(49);  enc_check("cw_before", 2'b00);
      cycles(1);   enc_check("cw_step1", 2'b10);
      read_check("cw_pos1", 1'b1, 32'hFFFF_FFFF);
      cycles(50);  enc_check("cw_step2", 2'b11);
      cycles(50);  enc_check("cw_step3", 2'b01);
      cycles(50);  enc_check("cw_step4", 2'b00);
      cycles(1800);
      read_check("cw_pos_2000", 1'b1, 32'hFFFF_FFF6);

`ifdef QENC_INDEX_EN
      // Speed 10, CPR 28: index high for 10 cycles every 280
      #3 rst_reset_n = 1'b0;
      @(negedge clk_clk);
      rst_reset_n = 1'b1;
      check_eq("idx_reset", {31'd0, index_out}, 32'd0);
      bus_write(1'b0, 32'd10);
      cycles(279); check_eq("idx_before", {31'd0, index_out}, 32'd0);
      cycles(1);   check_eq("idx_rise", {31'd0, index_out}, 32'd1);
      cycles(9);   check_eq("idx_last", {31'd0, index_out}, 32'd1);
      cycles(1);   check_eq("idx_fall", {31'd0, index_out}, 32'd0);
      cycles(269); check_eq("idx_before2", {31'd0, index_out}, 32'd0);
      cycles(1);   check_eq("idx_rise2", {31'd0, index_out}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/quadrature_encoder_gen.md
QUADRATURE_ENCODER_GEN -- requirements
Module: quadrature_encoder_gen

Interface
REQ-001 Parameter PERIOD_W, default 24: width of the step-period magnitude register.
REQ-002 Parameter POS_W, default 32: width of the position counter (POS_W <= 32).
REQ-003 Parameter CPR, default 28: quadrature steps per output revolution, used only under QENC_INDEX_EN.
REQ-004 clk_clk  in  1  system clock, 50 MHz.
REQ-005 rst_reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 avalon_slave_address  in  1  0 = speed register, 1 = position register.
REQ-007 avalon_slave_writedata  in  32  write data.
REQ-008 avalon_slave_readdata  out  32  read data, zero wait states.
REQ-009 avalon_slave_write  in  1  write strobe, one cycle per access.
REQ-010 avalon_slave_read  in  1  read strobe; has no side effects.
REQ-011 encoded_out  out  2  {A, B} emulated quadrature encoder channels; bit 1 = A, bit 0 = B.
REQ-012 index_out  out  1  once-per-revolution pulse; present only under QENC_INDEX_EN.

Function
REQ-013 The speed register SHALL be 32-bit two's complement: sign = direction, magnitude = clocks per quadrature step, 0 = stopped.
REQ-014 Positive speed SHALL emit the CCW sequence AB 00->01->11->10->00, so B = 1 at every A rising edge.
REQ-015 Negative speed SHALL emit the CW sequence AB 00->10->11->01->00, so B = 0 at every A rising edge.
REQ-016 Magnitude SHALL saturate to 2^PERIOD_W-1; a nonzero magnitude below 2 SHALL be clamped to 2.
REQ-017 FSM states: STOP, RUN. STOP->RUN on a write of a nonzero speed; RUN->STOP when a step boundary is reached with stored speed 0.
REQ-018 In STOP, the step timer SHALL be loaded with the magnitude in the cycle after the write; the first edge SHALL appear exactly magnitude cycles after the write cycle.
REQ-019 In RUN, the timer SHALL count down by 1 per clock; at timer = 1 the phase SHALL advance one step and the timer SHALL reload from the currently stored speed.
REQ-020 A speed write in RUN SHALL NOT disturb the current timer; the new magnitude and direction SHALL take effect at the next step boundary.
REQ-021 A direction reversal SHALL step backward from the current phase; the phase SHALL never jump by two steps.
REQ-022 encoded_out SHALL be driven directly from registers (glitch-free) and SHALL hold its last value in STOP.
REQ-023 The position counter SHALL add +1 on each emitted A rising edge in CCW and -1 in CW, with POS_W-bit wrap-around.
REQ-024 A write to address 1 SHALL load the position counter with writedata[POS_W-1:0]; if a write and an A rising edge fall in the same cycle, the write wins.
REQ-025 A read SHALL return the stored speed (address 0) or the sign-extended position (address 1), combinationally from registers.

Reset
REQ-026 While rst_reset_n = 0: encoded_out = 00, speed = 0, timer = 0, position = 0, FSM = STOP, index_out = 0.
REQ-027 Assertion mid-step SHALL abort immediately; after release, no edge SHALL occur until a new speed write.

Configuration
REQ-028 QENC_INDEX_EN defined: a modulo-CPR step counter runs, incremented in CCW and decremented in CW, and index_out is high for exactly the step interval while the count = 0.
REQ-029 QENC_INDEX_EN undefined: the index_out port, the step counter and the CPR logic are absent.

Structure
REQ-030 Package quadrature_encoder_pkg SHALL hold the FSM state typedef, the Gray phase constants (00, 01, 11, 10), and the minimum-period constant 2.
REQ-031 Sub-module quadrature_phase_stepper SHALL hold the 2-bit phase register with step/direction inputs and the A-rising-edge flag output.

Verification
REQ-032 Write speed = 100 from STOP -> first edge (AB 00->01) exactly 100 cycles after the write; then one step every 100 cycles; position +1 every 400 cycles.
REQ-033 Write speed = -50 -> sequence 00->10->11->01; after 2000 cycles, position reads 0xFFFFFFF6 (-10).
REQ-034 Running at 100, write -100 at mid-step -> the current step completes at 100 cycles, then the phase moves backward one step with no double step.
REQ-035 Write speed = 1 -> clamped to a step every 2 cycles; write speed = 0 -> FSM returns to STOP at the next boundary with AB held.
REQ-036 Load position 0x7FFFFFFF with CCW running -> the next A rise reads 0x80000000; a position write in the same cycle as an A rise -> the written value is kept.
REQ-037 With QENC_INDEX_EN and CPR = 28 at speed 10 -> index_out is high for 10 cycles, once every 280 cycles.
